// File: rtl/vdp_pkg.sv
// Shared types and constants for the VDP host port: port map, memory targets,
// FSM states and the data-port access codes.
package vdp_pkg;

  typedef enum logic [2:0] {
    PORT_DATA    = 3'b000,
    PORT_CTRL    = 3'b001,
    PORT_HV0     = 3'b010,
    PORT_HV1     = 3'b011,
    PORT_PSG0    = 3'b100,
    PORT_PSG1    = 3'b101,
    PORT_UNUSED0 = 3'b110,
    PORT_UNUSED1 = 3'b111
  } port_sel_e;

  typedef enum logic [1:0] {
    TGT_VRAM  = 2'd0,
    TGT_CRAM  = 2'd1,
    TGT_VSRAM = 2'd2
  } mem_target_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MEM_WAIT,
    ST_DONE
  } state_e;

  localparam logic [3:0] VRAM_WR  = 4'b0001;
  localparam logic [3:0] CRAM_WR  = 4'b0011;
  localparam logic [3:0] VSRAM_WR = 4'b0101;
  localparam logic [3:0] VRAM_RD  = 4'b0000;
  localparam logic [3:0] CRAM_RD  = 4'b1000;
  localparam logic [3:0] VSRAM_RD = 4'b0100;

  localparam logic [2:0] REG_WR_PATTERN = 3'b100;

  typedef struct packed {
    logic        valid;
    logic        we;
    mem_target_e target;
  } mem_op_t;

  // A code is only usable when its direction matches the bus cycle direction.
  function automatic mem_op_t decode_code(input logic [3:0] code, input logic rnw);
    mem_op_t op;
    op = '{valid: 1'b0, we: 1'b0, target: TGT_VRAM};
    case (code)
      VRAM_WR:  op = '{valid: ~rnw, we: 1'b1, target: TGT_VRAM};
      CRAM_WR:  op = '{valid: ~rnw, we: 1'b1, target: TGT_CRAM};
      VSRAM_WR: op = '{valid: ~rnw, we: 1'b1, target: TGT_VSRAM};
      VRAM_RD:  op = '{valid: rnw,  we: 1'b0, target: TGT_VRAM};
      CRAM_RD:  op = '{valid: rnw,  we: 1'b0, target: TGT_CRAM};
      VSRAM_RD: op = '{valid: rnw,  we: 1'b0, target: TGT_VSRAM};
      default:  ;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/vdp_host_port_ctrl_latch.sv
// Two-word control-port latch: holds pending/code/addr, decodes register writes
// and applies data-port address increments and pending clears.
module vdp_host_port_ctrl_latch
  import vdp_pkg::*;
(
  input  logic        clk,
  input  logic        srst_n,
  input  logic        ctrl_wr,
  input  logic [15:0] ctrl_wdata,
  input  logic        pending_clr,
  input  logic        addr_inc,
  input  logic [7:0]  autoinc,
  output logic        pending,
  output logic [5:0]  code,
  output logic [15:0] addr,
  output logic        reg_we,
  output logic [4:0]  reg_idx,
  output logic [7:0]  reg_wdata
);

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      pending   <= 1'b0;
      code      <= 6'd0;
      addr      <= 16'd0;
      reg_we    <= 1'b0;
      reg_idx   <= 5'd0;
      reg_wdata <= 8'd0;
    end else begin
      reg_we <= 1'b0;
      if (ctrl_wr) begin
        // The second word is always taken as address/code, even if it looks
        // like a register write.
        if (pending) begin
          code[5:2]   <= ctrl_wdata[7:4];
          addr[15:14] <= ctrl_wdata[1:0];
          pending     <= 1'b0;
        end else if (ctrl_wdata[15:13] == REG_WR_PATTERN) begin
          reg_we    <= 1'b1;
          reg_idx   <= ctrl_wdata[12:8];
          reg_wdata <= ctrl_wdata[7:0];
        end else begin
          code[1:0]  <= ctrl_wdata[15:14];
          addr[13:0] <= ctrl_wdata[13:0];
          pending    <= 1'b1;
        end
      end else begin
        if (pending_clr) pending <= 1'b0;
        if (addr_inc)    addr    <= addr + {8'h00, autoinc};
      end
    end
  end

endmodule

// File: rtl/vdp_host_port.sv
// VDP bus front end: decodes the port map, acknowledges every bus cycle and
// turns data-port accesses into VRAM/CRAM/VSRAM requests.
module vdp_host_port
  import vdp_pkg::*;
(
  input  logic        clk,
  input  logic        srst_n,
  input  logic        vdp_sel,
  input  logic        vdp_rnw,
  input  logic [4:0]  vdp_a,
  input  logic [15:0] vdp_di,
  output logic [15:0] vdp_do,
  output logic        vdp_dtack_n,
  input  logic [15:0] status,
  input  logic [15:0] hv_count,
  input  logic [7:0]  autoinc,
  output logic        reg_we,
  output logic [4:0]  reg_idx,
  output logic [7:0]  reg_wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [1:0]  mem_target,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata
);

  state_e      state;
  port_sel_e   port;
  mem_op_t     op;
  logic        start;
  logic        ctrl_wr;
  logic        pending_clr;
  logic        addr_inc;
  logic        pending;
  logic [5:0]  code;
  logic [15:0] addr;
  logic        unused_bits;

  assign port        = port_sel_e'(vdp_a[4:2]);
  assign op          = decode_code(code[3:0], vdp_rnw);
  assign start       = (state == ST_IDLE) && vdp_sel;
  assign ctrl_wr     = start && (port == PORT_CTRL) && !vdp_rnw;
  assign pending_clr = start && ((port == PORT_DATA) || ((port == PORT_CTRL) && vdp_rnw));
  // Invalid data accesses still advance the address, just without a request.
  assign addr_inc    = (start && (port == PORT_DATA) && !op.valid) ||
                       ((state == ST_MEM_WAIT) && mem_ack);
  assign unused_bits = ^{vdp_a[1:0], code[5:4], pending};

  vdp_host_port_ctrl_latch u_latch (
    .clk         (clk),
    .srst_n      (srst_n),
    .ctrl_wr     (ctrl_wr),
    .ctrl_wdata  (vdp_di),
    .pending_clr (pending_clr),
    .addr_inc    (addr_inc),
    .autoinc     (autoinc),
    .pending     (pending),
    .code        (code),
    .addr        (addr),
    .reg_we      (reg_we),
    .reg_idx     (reg_idx),
    .reg_wdata   (reg_wdata)
  );

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      state       <= ST_IDLE;
      vdp_do      <= 16'd0;
      vdp_dtack_n <= 1'b1;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_target  <= 2'd0;
      mem_addr    <= 16'd0;
      mem_wdata   <= 16'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (vdp_sel) begin
            if ((port == PORT_DATA) && op.valid) begin
              mem_req    <= 1'b1;
              mem_we     <= op.we;
              mem_target <= op.target;
              mem_addr   <= addr;
              mem_wdata  <= vdp_di;
              vdp_do     <= 16'd0;
              state      <= ST_MEM_WAIT;
            end else begin
              vdp_dtack_n <= 1'b0;
              state       <= ST_DONE;
              case (port)
                PORT_DATA:         vdp_do <= 16'd0;
                PORT_CTRL:         vdp_do <= vdp_rnw ? status   : 16'd0;
                PORT_HV0, PORT_HV1: vdp_do <= vdp_rnw ? hv_count : 16'd0;
                default:           vdp_do <= vdp_rnw ? 16'hFFFF : 16'd0;
              endcase
            end
          end
        end
        ST_MEM_WAIT: begin
          if (mem_ack) begin
            mem_req     <= 1'b0;
            vdp_dtack_n <= 1'b0;
            if (!mem_we) vdp_do <= mem_rdata;
            state       <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!vdp_sel) begin
            vdp_dtack_n <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vdp_host_port.sv
// Scoreboard bench for vdp_host_port: expected register writes, memory requests
// and read data are queued when a bus cycle is issued and checked as they appear.
module tb_vdp_host_port;

  logic        clk;
  logic        srst_n;
  logic        vdp_sel;
  logic        vdp_rnw;
  logic [4:0]  vdp_a;
  logic [15:0] vdp_di;
  logic [15:0] vdp_do;
  logic        vdp_dtack_n;
  logic [15:0] status;
  logic [15:0] hv_count;
  logic [7:0]  autoinc;
  logic        reg_we;
  logic [4:0]  reg_idx;
  logic [7:0]  reg_wdata;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_target;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;

  typedef struct packed {
    logic [4:0] idx;
    logic [7:0] data;
  } reg_exp_t;

  typedef struct packed {
    logic        we;
    logic [1:0]  tgt;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        chk_wdata;
  } mem_exp_t;

  reg_exp_t    exp_reg_q[$];
  mem_exp_t    exp_mem_q[$];
  logic [15:0] exp_rd_q[$];

  int          vectors;
  int          miscompares;
  logic        mem_req_q;
  logic        resp_en;
  int          ack_delay;
  logic [15:0] rdata_val;
  logic [15:0] m_addr;
  logic [15:0] wd;
  reg_exp_t    re;
  mem_exp_t    me;

  vdp_host_port dut (
    .clk         (clk),
    .srst_n      (srst_n),
    .vdp_sel     (vdp_sel),
    .vdp_rnw     (vdp_rnw),
    .vdp_a       (vdp_a),
    .vdp_di      (vdp_di),
    .vdp_do      (vdp_do),
    .vdp_dtack_n (vdp_dtack_n),
    .status      (status),
    .hv_count    (hv_count),
    .autoinc     (autoinc),
    .reg_we      (reg_we),
    .reg_idx     (reg_idx),
    .reg_wdata   (reg_wdata),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_target  (mem_target),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic pushReg(input logic [4:0] idx, input logic [7:0] data);
    exp_reg_q.push_back('{idx: idx, data: data});
  endtask

  task automatic pushMem(input logic we, input logic [1:0] tgt, input logic [15:0] addr,
                         input logic [15:0] wdata);
    exp_mem_q.push_back('{we: we, tgt: tgt, addr: addr, wdata: wdata, chk_wdata: we});
  endtask

  // One complete bus cycle: raise sel, wait for DTACK, check read data and hold, drop sel.
  task automatic applyStimulus(input logic [4:0] a, input logic rnw, input logic [15:0] di,
                               input int exp_lat);
    int cycles;
    logic [15:0] exp_rd;
    @(negedge clk);
    vdp_a   = a;
    vdp_rnw = rnw;
    vdp_di  = di;
    vdp_sel = 1'b1;
    cycles  = 0;
    while (vdp_dtack_n && cycles < 64) begin
      @(negedge clk);
      cycles++;
    end
    if (vdp_dtack_n) begin
      checkOutput("dtack_timeout", 32'd1, 32'd0);
    end else begin
      if (exp_lat > 0) checkOutput("dtack_latency", 32'(cycles), 32'(exp_lat));
      if (rnw) begin
        if (exp_rd_q.size() == 0) begin
          checkOutput("rd_unexpected", 32'd1, 32'd0);
        end else begin
          exp_rd = exp_rd_q.pop_front();
          checkOutput("rd_data", 32'(vdp_do), 32'(exp_rd));
          @(negedge clk);
          checkOutput("rd_hold", 32'({vdp_dtack_n, vdp_do}), 32'({1'b0, exp_rd}));
        end
      end
    end
    vdp_sel = 1'b0;
    @(negedge clk);
    checkOutput("dtack_release", 32'(vdp_dtack_n), 32'd1);
  endtask

  // Memory model: acknowledges each request ack_delay cycles after it appears.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 16'd0;
    forever begin
      @(negedge clk);
      if (mem_req && resp_en && !mem_ack) begin
        repeat (ack_delay - 1) @(negedge clk);
        mem_rdata = rdata_val;
        mem_ack   = 1'b1;
        @(negedge clk);
        mem_ack   = 1'b0;
      end
    end
  end

  // Output monitor: pops expectations as register strobes and memory requests appear.
  always @(negedge clk) begin
    if (srst_n) begin
      if (reg_we) begin
        if (exp_reg_q.size() == 0) begin
          checkOutput("reg_we_unexpected", 32'd1, 32'd0);
        end else begin
          re = exp_reg_q.pop_front();
          checkOutput("reg_idx", 32'(reg_idx), 32'(re.idx));
          checkOutput("reg_wdata", 32'(reg_wdata), 32'(re.data));
        end
      end
      if (mem_req && !mem_req_q) begin
        if (exp_mem_q.size() == 0) begin
          checkOutput("mem_req_unexpected", 32'd1, 32'd0);
        end else begin
          me = exp_mem_q.pop_front();
          checkOutput("mem_we", 32'(mem_we), 32'(me.we));
          checkOutput("mem_target", 32'(mem_target), 32'(me.tgt));
          checkOutput("mem_addr", 32'(mem_addr), 32'(me.addr));
          if (me.chk_wdata) checkOutput("mem_wdata", 32'(mem_wdata), 32'(me.wdata));
        end
      end
    end
    mem_req_q = mem_req;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    mem_req_q   = 1'b0;
    resp_en     = 1'b1;
    ack_delay   = 1;
    rdata_val   = 16'd0;
    srst_n      = 1'b0;
    vdp_sel     = 1'b0;
    vdp_rnw     = 1'b0;
    vdp_a       = 5'd0;
    vdp_di      = 16'd0;
    status      = 16'd0;
    hv_count    = 16'd0;
    autoinc     = 8'd2;

    repeat (3) @(negedge clk);
    checkOutput("rst_dtack_n", 32'(vdp_dtack_n), 32'd1);
    checkOutput("rst_outputs", 32'({vdp_do, reg_we, reg_idx, reg_wdata, mem_req, mem_we, mem_target}),
                32'd0);
    checkOutput("rst_mem_addr", 32'({mem_addr, mem_wdata}), 32'd0);
    srst_n = 1'b1;

    // Register write through the control port.
    pushReg(5'd1, 8'h44);
    applyStimulus(5'h04, 1'b0, 16'h8144, 1);
    checkOutput("reg_wr_pending", 32'(dut.u_latch.pending), 32'd0);

    // VRAM write at 0x0000 with a slow ack, then auto-incremented address.
    applyStimulus(5'h04, 1'b0, 16'h4000, 1);
    applyStimulus(5'h04, 1'b0, 16'h0000, 1);
    ack_delay = 3;
    pushMem(1'b1, 2'd0, 16'h0000, 16'h1234);
    applyStimulus(5'h00, 1'b0, 16'h1234, 4);
    ack_delay = 1;
    pushMem(1'b1, 2'd0, 16'h0002, 16'h5678);
    applyStimulus(5'h00, 1'b0, 16'h5678, 2);
    checkOutput("vram_wr_addr", 32'(dut.u_latch.addr), 32'h0004);

    // CRAM read returns memory data on vdp_do.
    applyStimulus(5'h04, 1'b0, 16'h0000, 1);
    applyStimulus(5'h04, 1'b0, 16'h0020, 1);
    ack_delay = 2;
    rdata_val = 16'h0EEE;
    pushMem(1'b0, 2'd1, 16'h0000, 16'h0000);
    exp_rd_q.push_back(16'h0EEE);
    applyStimulus(5'h00, 1'b1, 16'h0000, 3);

    // Status read clears a half-written address; then register 15 write.
    applyStimulus(5'h04, 1'b0, 16'h4000, 1);
    status = 16'h3400;
    exp_rd_q.push_back(16'h3400);
    applyStimulus(5'h04, 1'b1, 16'h0000, 1);
    checkOutput("status_rd_pending", 32'(dut.u_latch.pending), 32'd0);
    pushReg(5'd15, 8'h02);
    applyStimulus(5'h04, 1'b0, 16'h8F02, 1);

    // Second word that matches the register-write pattern is still address/code.
    applyStimulus(5'h04, 1'b0, 16'h4000, 1);
    applyStimulus(5'h04, 1'b0, 16'h8F02, 1);
    checkOutput("second_word_addr", 32'(dut.u_latch.addr), 32'h8000);
    checkOutput("second_word_code", 32'(dut.u_latch.code), 32'h01);

    // HV counter, PSG and unused ports, plus a mirrored control-port address.
    hv_count = 16'hABCD;
    exp_rd_q.push_back(16'hABCD);
    applyStimulus(5'h08, 1'b1, 16'h0000, 1);
    hv_count = 16'h1357;
    exp_rd_q.push_back(16'h1357);
    applyStimulus(5'h0C, 1'b1, 16'h0000, 1);
    exp_rd_q.push_back(16'hFFFF);
    applyStimulus(5'h14, 1'b1, 16'h0000, 1);
    exp_rd_q.push_back(16'hFFFF);
    applyStimulus(5'h1B, 1'b1, 16'h0000, 1);
    applyStimulus(5'h10, 1'b0, 16'h8123, 1);
    applyStimulus(5'h18, 1'b0, 16'h4000, 1);
    pushReg(5'd2, 8'h03);
    applyStimulus(5'h07, 1'b0, 16'h8203, 1);
    checkOutput("ignored_wr_addr", 32'(dut.u_latch.addr), 32'h8000);

    // Direction mismatch and an invalid code both skip memory but advance addr.
    autoinc = 8'h10;
    exp_rd_q.push_back(16'h0000);
    applyStimulus(5'h00, 1'b1, 16'h0000, 1);
    checkOutput("mismatch_addr", 32'(dut.u_latch.addr), 32'h8010);
    applyStimulus(5'h04, 1'b0, 16'h0000, 1);
    applyStimulus(5'h04, 1'b0, 16'h0000, 1);
    applyStimulus(5'h00, 1'b0, 16'hBEEF, 1);
    checkOutput("invalid_addr", 32'(dut.u_latch.addr), 32'h0010);
    checkOutput("invalid_pending", 32'(dut.u_latch.pending), 32'd0);

    // VSRAM write, VSRAM read and CRAM write codes.
    autoinc = 8'h02;
    applyStimulus(5'h04, 1'b0, 16'h4010, 1);
    applyStimulus(5'h04, 1'b0, 16'h0010, 1);
    pushMem(1'b1, 2'd2, 16'h0010, 16'h0A5A);
    applyStimulus(5'h00, 1'b0, 16'h0A5A, 3);
    applyStimulus(5'h04, 1'b0, 16'h0020, 1);
    applyStimulus(5'h04, 1'b0, 16'h0010, 1);
    rdata_val = 16'h07C3;
    pushMem(1'b0, 2'd2, 16'h0020, 16'h0000);
    exp_rd_q.push_back(16'h07C3);
    applyStimulus(5'h00, 1'b1, 16'h0000, 3);
    applyStimulus(5'h04, 1'b0, 16'hC004, 1);
    applyStimulus(5'h04, 1'b0, 16'h0000, 1);
    pushMem(1'b1, 2'd1, 16'h0004, 16'h0E0E);
    applyStimulus(5'h00, 1'b0, 16'h0E0E, 3);

    // Address wrap from 0xFFFF, followed by a run of writes with a large increment.
    applyStimulus(5'h04, 1'b0, 16'h7FFF, 1);
    applyStimulus(5'h04, 1'b0, 16'h0003, 1);
    pushMem(1'b1, 2'd0, 16'hFFFF, 16'h1111);
    applyStimulus(5'h00, 1'b0, 16'h1111, 3);
    m_addr  = 16'h0001;
    autoinc = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      wd = 16'($urandom);
      pushMem(1'b1, 2'd0, m_addr, wd);
      applyStimulus(5'h00, 1'b0, wd, 3);
      m_addr = m_addr + 16'h00FF;
    end
    checkOutput("autoinc_run_addr", 32'(dut.u_latch.addr), 32'(m_addr));

    // Reset while waiting for memory aborts the request immediately.
    resp_en = 1'b0;
    applyStimulus(5'h04, 1'b0, 16'h4000, 1);
    applyStimulus(5'h04, 1'b0, 16'h0000, 1);
    pushMem(1'b1, 2'd0, 16'h0000, 16'h2222);
    @(negedge clk);
    vdp_a   = 5'h00;
    vdp_rnw = 1'b0;
    vdp_di  = 16'h2222;
    vdp_sel = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("mid_rst_req_before", 32'(mem_req), 32'd1);
    srst_n = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_req", 32'(mem_req), 32'd0);
    checkOutput("mid_rst_dtack_n", 32'(vdp_dtack_n), 32'd1);
    vdp_sel = 1'b0;
    @(negedge clk);
    srst_n  = 1'b1;
    resp_en = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("post_rst_idle", 32'({mem_req, vdp_dtack_n}), 32'b01);

    checkOutput("reg_q_left", 32'(exp_reg_q.size()), 32'd0);
    checkOutput("mem_q_left", 32'(exp_mem_q.size()), 32'd0);
    checkOutput("rd_q_left", 32'(exp_rd_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
